program_loader: RTL

- Upstream feeder for multicore_cpu's instruction/data memory programming port (w_instruction, w_adrs, w_enable, cpu_en).
- Accepts a byte stream (e.g. from a UART receiver) carrying a framed program image and packs bytes into 32-bit words.
- Writes each word to consecutive memory addresses while holding the CPU disabled.
- On a valid checksum, releases the CPU by asserting cpu_en. Replaces manual bench-driven programming.

---
 rtl/program_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: unpacks a framed image (SYNC, address, word
// count, data, XOR checksum) into CPU memory writes, then releases the CPU.
module program_loader #(
  parameter int DATA_SIZE = 32,
  parameter int ADRS_SIZE = 11,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [DATA_SIZE-1:0] w_instruction,
  output logic [ADRS_SIZE-1:0] w_adrs,
  output logic                 w_enable,
  output logic                 cpu_en,
  output logic                 busy,
  output logic                 load_done,
  output logic                 load_error
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CHK, S_RUN} state_t;

  state_t               state_q, state_d;
  logic [1:0]           bcnt_q, bcnt_d;
  logic [23:0]          hdr_q, hdr_d;
  logic [DATA_SIZE-1:0] word_q, word_d;
  logic [ADRS_SIZE-1:0] addr_q, addr_d;
  logic [15:0]          wcnt_q, wcnt_d;
  logic [7:0]           xor_q, xor_d;
  logic [TW-1:0]        idle_q, idle_d;
  logic [DATA_SIZE-1:0] winst_q, winst_d;
  logic [ADRS_SIZE-1:0] wadrs_q, wadrs_d;
  logic                 wen_q, wen_d;
  logic                 cpu_en_q, cpu_en_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic        take;
  logic [31:0] hdr_full;
  logic        in_frame;

  // rx_ready is unconditionally high, so every valid byte is taken.
  assign take     = rx_valid;
  assign hdr_full = {hdr_q, rx_data};
  assign in_frame = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    hdr_d   = hdr_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    xor_d   = xor_q;
    idle_d  = idle_q;
    winst_d = winst_q;
    wadrs_d = wadrs_q;
    wen_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE, S_RUN: begin
        if (take && rx_data == SYNC) begin
          state_d = S_HDR;
          bcnt_d  = 2'd0;
          xor_d   = 8'h00;
          err_d   = 1'b0;
        end
      end
      S_HDR: begin
        if (take) begin
          xor_d  = xor_q ^ rx_data;
          hdr_d  = hdr_full[23:0];
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            addr_d  = hdr_full[16 +: ADRS_SIZE];
            wcnt_d  = hdr_full[15:0];
            state_d = (hdr_full[15:0] != 16'd0) ? S_DATA : S_CHK;
          end
        end
      end
      S_DATA: begin
        if (take) begin
          xor_d  = xor_q ^ rx_data;
          word_d = {word_q[DATA_SIZE-9:0], rx_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wen_d   = 1'b1;
            winst_d = word_d;
            wadrs_d = addr_q;
            addr_d  = addr_q + 1'b1;
            wcnt_d  = wcnt_q - 1'b1;
            if (wcnt_q == 16'd1) state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (take) begin
          if (rx_data == xor_q) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Idle watchdog only runs inside a frame; an accepted byte always rearms it.
    if (!in_frame || take) begin
      idle_d = '0;
    end else if (idle_q == TW'(TIMEOUT - 1)) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      idle_d  = '0;
    end else begin
      idle_d = idle_q + 1'b1;
    end

    cpu_en_d = (state_d == S_RUN);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bcnt_q   <= '0;
      hdr_q    <= '0;
      word_q   <= '0;
      addr_q   <= '0;
      wcnt_q   <= '0;
      xor_q    <= '0;
      idle_q   <= '0;
      winst_q  <= '0;
      wadrs_q  <= '0;
      wen_q    <= 1'b0;
      cpu_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      hdr_q    <= hdr_d;
      word_q   <= word_d;
      addr_q   <= addr_d;
      wcnt_q   <= wcnt_d;
      xor_q    <= xor_d;
      idle_q   <= idle_d;
      winst_q  <= winst_d;
      wadrs_q  <= wadrs_d;
      wen_q    <= wen_d;
      cpu_en_q <= cpu_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign rx_ready      = 1'b1;
  assign w_instruction = winst_q;
  assign w_adrs        = wadrs_q;
  assign w_enable      = wen_q;
  assign cpu_en        = cpu_en_q;
  assign busy          = in_frame;
  assign load_done     = done_q;
  assign load_error    = err_q;

endmodule
